// File: rtl/result_drain.sv
// result_drain: streams the 16 systolic-array results out of the output memory over valid/ready.
// Define RESULT_DRAIN_TRANSPOSE_EN to walk the memory column-major instead of row-major.
module result_drain #(
  parameter int N      = 4,
  parameter int DATA_W = 33,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(N * N);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] issue_q, issue_d, beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_k, idx1_q, idx2_q;
  logic p1_q, p2_q, done_q, done_d;
  logic [1:0] cnt_q, cnt_d, wr;
  logic [2:0] occ;
  logic [DATA_W-1:0] data_q [3];
  logic [DATA_W-1:0] data_d [3];
  logic [ADDR_W-1:0] idx_q [3];
  logic [ADDR_W-1:0] idx_d [3];
  logic accept, issue, pop, push, last_pop;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
  assign addr_k = ADDR_W'((int'(issue_q) % N) * N + int'(issue_q) / N);
`else
  assign addr_k = issue_q[ADDR_W-1:0];
`endif
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign mem_read_addr = addr_q;
  assign out_valid     = cnt_q != 2'd0;
  assign out_data      = data_q[0];
  assign out_index     = idx_q[0];
  assign out_last      = out_valid && beat_q == DEPTH - 1'b1;
  // Next state, counters and read issue; occupancy counts this cycle's pop so the stream runs at full rate
  always_comb begin
    accept   = state_q == IDLE && start && !done_q;
    pop      = out_valid && out_ready;
    push     = p2_q;
    last_pop = pop && beat_q == DEPTH - 1'b1;
    occ      = {1'b0, cnt_q} + {2'b0, p1_q} + {2'b0, p2_q} - {2'b0, pop};
    issue    = (accept || state_q == RUN) && occ < 3'd3;
    issue_d  = last_pop ? '0 : issue_q + CW'(issue);
    beat_d   = last_pop ? '0 : beat_q + CW'(pop);
    addr_d   = issue ? addr_k : addr_q;
    done_d   = last_pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    wr       = cnt_q - {1'b0, pop};
    state_d  = accept ? RUN :
               (state_q == RUN && issue && issue_q == DEPTH - 1'b1) ? FLUSH :
               last_pop ? IDLE : state_q;
  end
  // Output buffer: head shifts out on pop, returning read data lands behind the surviving entries
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (pop) begin
      data_d[0] = data_q[1];
      data_d[1] = data_q[2];
      idx_d[0]  = idx_q[1];
      idx_d[1]  = idx_q[2];
    end
    if (push) begin
      data_d[wr] = mem_read_data;
      idx_d[wr]  = idx2_q;
    end
  end
  // State, counters, two-stage read-latency pipe and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      issue_q <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      p1_q    <= issue;
      p2_q    <= p1_q;
      idx1_q  <= addr_k;
      idx2_q  <= idx1_q;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed checks of the result drain against a registered-read memory model.
module tb_result_drain;
  logic clk = 1'b0;
  logic rst, start, out_ready, busy, done, out_valid, out_last;
  logic [3:0] mem_read_addr, out_index;
  logic [32:0] mem_read_data, out_data;
  logic [32:0] mem [16];
  int total = 0, bad = 0;
  result_drain dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_read_data <= mem[mem_read_addr];
  function automatic logic [3:0] exp_addr(input int k);
`ifdef RESULT_DRAIN_TRANSPOSE_EN
    return 4'((k % 4) * 4 + k / 4);
`else
    return 4'(k);
`endif
  endfunction
  function automatic logic [32:0] exp_data(input logic [3:0] a);
    return {1'b1, 32'(a) * 32'd3};
  endfunction
  task test_reset;
    rst = 1; start = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %0b want 0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got %0b want 0", out_last); end
    total++; if (out_data !== 33'd0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
    total++; if (out_index !== 4'd0) begin bad++; $display("FAIL reset_index got %0d want 0", out_index); end
    total++; if (mem_read_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", mem_read_addr); end
    rst = 0;
  endtask
  task test_stream;
    logic ev;
    @(negedge clk); start = 1; out_ready = 1;
    @(negedge clk); start = 0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stream_e0 valid=%0b busy=%0b want 0/1", out_valid, busy); end
    total++; if (mem_read_addr !== exp_addr(0)) begin bad++; $display("FAIL stream_addr0 got %0d want %0d", mem_read_addr, exp_addr(0)); end
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      ev = c >= 2 && c <= 17;
      total++;
      if (out_valid !== ev || busy !== (c <= 17) || done !== (c == 18) ||
          (ev && (out_index !== exp_addr(c - 2) || out_data !== exp_data(exp_addr(c - 2)) || out_last !== (c == 17)))) begin
        bad++;
        $display("FAIL stream_c%0d got v=%0b b=%0b d=%0b i=%0d data=%h l=%0b want v=%0b b=%0b d=%0b i=%0d l=%0b",
                 c, out_valid, busy, done, out_index, out_data, out_last, ev, c <= 17, c == 18, exp_addr(c - 2), c == 17);
      end
      start = c == 18;
    end
    start = 0;
  endtask
  task test_backpressure;
    int nb, stall, dones;
    logic pv, pr, sent;
    nb = 0; stall = 0; dones = 0; pv = 0; pr = 0; sent = 0;
    @(negedge clk); start = 1; out_ready = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 0;
      if (pv && !pr) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d valid got %0b want 1", cyc, out_valid); end
      end
      if (out_valid) begin
        total++;
        if (nb >= 16) begin bad++; $display("FAIL bp_extra index got %0d want no beat", out_index); end
        else if (out_index !== exp_addr(nb) || out_data !== exp_data(exp_addr(nb)) || out_last !== (nb == 15)) begin
          bad++; $display("FAIL bp_beat%0d got i=%0d data=%h l=%0b want i=%0d data=%h l=%0b", nb, out_index, out_data, out_last, exp_addr(nb), exp_data(exp_addr(nb)), nb == 15);
        end
      end
      if (done) dones++;
      if (nb >= 8 && stall < 6) begin out_ready = 0; stall++; end
      else if (stall >= 6) out_ready = ~out_ready;
      if (nb == 5 && !sent) begin start = 1; sent = 1; end
      if (out_valid && out_ready) nb++;
      pv = out_valid; pr = out_ready;
    end
    out_ready = 1; start = 0;
    total++; if (nb !== 16) begin bad++; $display("FAIL bp_count got %0d want 16", nb); end
    total++; if (dones !== 1) begin bad++; $display("FAIL bp_dones got %0d want 1", dones); end
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle busy=%0b valid=%0b want 0/0", busy, out_valid); end
  endtask
  task test_mid_reset;
    int nb;
    nb = 0;
    @(negedge clk); start = 1; out_ready = 1;
    for (int c = 0; c < 40 && nb < 10; c++) begin
      @(negedge clk);
      start = 0;
      if (out_valid && out_ready) nb++;
    end
    total++; if (nb !== 10) begin bad++; $display("FAIL mr_reach got %0d beats want 10", nb); end
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL mr_after got b=%0b v=%0b d=%0b l=%0b want 0", busy, out_valid, done, out_last);
    end
    total++; if (out_index !== 4'd0 || mem_read_addr !== 4'd0) begin bad++; $display("FAIL mr_regs got i=%0d a=%0d want 0/0", out_index, mem_read_addr); end
    repeat (4) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_quiet valid got %0b want 0", out_valid); end
    end
    nb = 0;
    start = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 0;
      if (out_valid) begin
        total++;
        if (nb >= 16 || out_index !== exp_addr(nb) || out_data !== exp_data(exp_addr(nb))) begin
          bad++; $display("FAIL mr_beat%0d got i=%0d data=%h want i=%0d", nb, out_index, out_data, exp_addr(nb));
        end
        nb++;
      end
    end
    total++; if (nb !== 16) begin bad++; $display("FAIL mr_count got %0d want 16", nb); end
  endtask
  task test_hold;
    int nb, dones;
    nb = 0; dones = 0;
    @(negedge clk); start = 1; out_ready = 0;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_index !== exp_addr(0) || out_data !== exp_data(exp_addr(0))) begin
      bad++; $display("FAIL hold_head got v=%0b i=%0d data=%h want 1/%0d", out_valid, out_index, out_data, exp_addr(0));
    end
    total++; if (mem_read_addr !== exp_addr(2)) begin bad++; $display("FAIL hold_reads addr got %0d want %0d", mem_read_addr, exp_addr(2)); end
    repeat (5) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_index !== exp_addr(0) || mem_read_addr !== exp_addr(2) || busy !== 1'b1) begin
      bad++; $display("FAIL hold_still got v=%0b i=%0d a=%0d b=%0b want 1/%0d/%0d/1", out_valid, out_index, mem_read_addr, busy, exp_addr(0), exp_addr(2));
    end
    out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        total++;
        if (nb >= 16 || out_index !== exp_addr(nb) || out_data !== exp_data(exp_addr(nb)) || out_last !== (nb == 15)) begin
          bad++; $display("FAIL hold_beat%0d got i=%0d data=%h l=%0b want i=%0d", nb, out_index, out_data, out_last, exp_addr(nb));
        end
        nb++;
      end
      if (done) dones++;
      @(negedge clk);
    end
    total++; if (nb !== 16 || dones !== 1) begin bad++; $display("FAIL hold_count got beats=%0d dones=%0d want 16/1", nb, dones); end
  endtask
  initial begin
    for (int a = 0; a < 16; a++) mem[a] = exp_data(4'(a));
    test_reset;
    test_stream;
    test_backpressure;
    test_mid_reset;
    test_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
